// File: rtl/tri_bus_arb_mux.sv
// Round-robin arbiter driving a shared tri-state bus from N channels,
// with a bounded hold time and a high-Z turnaround gap between owners.
module tri_bus_arb_mux #(
  parameter int WIDTH    = 8,
  parameter int N        = 4,
  parameter int TURN     = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   din,
  output wire  [WIDTH-1:0]     bus_out,
  output logic [N-1:0]         oe,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 bus_valid
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    gap_q, gap_d;
  logic [N-1:0]  oe_q, oe_d;

  logic [IW-1:0] win;
  logic          found;
  logic [HW-1:0] hold_inc;
  logic          others;

  // Search starts just after the previous owner and wraps.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(last_q) + i) % N]) begin
        found = 1'b1;
        win   = IW'((int'(last_q) + i) % N);
      end
    end
  end

  assign hold_inc = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
  assign others   = |(req & ~(N'(1) << owner_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(N - 1);
      hold_q  <= '0;
      gap_q   <= '0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          owner_d = win;
          hold_d  = '0;
        end
      end
      OWN: begin
        hold_d = hold_inc;
        if (!req[owner_q] ||
            (hold_inc == HW'(MAX_HOLD) && others)) begin
          state_d = GAP;
          last_d  = owner_q;
          gap_d   = '0;
        end
      end
      GAP: begin
        gap_d = gap_q + 3'd1;
        if (gap_q == 3'(TURN - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oe_d = '0;
    if (state_d == OWN) oe_d = N'(1) << owner_d;
  end

  assign oe        = oe_q;
  assign grant_id  = owner_q;
  assign bus_valid = (state_q == OWN);

  for (genvar k = 0; k < N; k++) begin : g_drv
    assign bus_out = oe_q[k] ? din[k*WIDTH +: WIDTH] : {WIDTH{1'bz}};
  end

endmodule

// File: tb/tb_tri_bus_arb_mux.sv
// Directed bench for tri_bus_arb_mux: reset, grant latency, rotation,
// saturation, turnaround and mid-ownership reset.
module tb_tri_bus_arb_mux;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req2;
  logic [31:0] din;
  wire  [7:0]  bus_out;
  wire  [7:0]  bus2;
  logic [3:0]  oe, oe2;
  logic [1:0]  gid, gid2;
  logic        bv, bv2;
  logic        bz;

  int n_chk = 0;
  int n_fail = 0;

  tri_bus_arb_mux #(.WIDTH(8), .N(4), .TURN(1), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .bus_out(bus_out), .oe(oe), .grant_id(gid), .bus_valid(bv)
  );

  tri_bus_arb_mux dut16 (
    .clk(clk), .rst(rst), .req(req2), .din(din),
    .bus_out(bus2), .oe(oe2), .grant_id(gid2), .bus_valid(bv2)
  );

  assign bz = (bus_out === 8'bzzzzzzzz);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot", 32'($countones(oe) <= 1), 1);
      chk("onehot2", 32'($countones(oe2) <= 1), 1);
      if (bv) chk("bus_known", 32'($isunknown(bus_out)), 0);
    end
  end

  initial begin
    int o;
    rst  = 1'b1;
    req  = '0;
    req2 = '0;
    din  = {8'h4D, 8'h3C, 8'h2B, 8'hA5};
    #12;
    chk("rst_oe", oe, 0);
    chk("rst_bv", bv, 0);
    chk("rst_gid", gid, 0);
    chk("rst_z", bz, 1);
    step();
    rst = 1'b0;

    // single requester, one-cycle grant latency
    req = 4'b0001;
    step();
    chk("g0_oe", oe, 4'b0001);
    chk("g0_bus", bus_out, 8'hA5);
    chk("g0_gid", gid, 0);
    chk("g0_bv", bv, 1);

    // all request: rotate 0,1,2,3,0 for 4 cycles each
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      o = r % 4;
      for (int c = 0; c < 4; c++) begin
        step();
        chk("rr_oe", oe, 32'(1) << o);
        chk("rr_gid", gid, o);
        chk("rr_bus", bus_out, din[o*8 +: 8]);
        chk("rr_bv", bv, 1);
      end
      step();
      chk("gap_oe", oe, 0);
      chk("gap_bv", bv, 0);
      chk("gap_z", bz, 1);
      step();
      chk("idle_oe", oe, 0);
      chk("idle_z", bz, 1);
    end
    req = '0;

    // sole requester keeps the bus; saturated count yields at once
    req2 = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      step();
      chk("sole_oe", oe2, 4'b0100);
      chk("sole_gid", gid2, 2);
      chk("sole_bv", bv2, 1);
    end
    req2 = 4'b0101;
    step();
    chk("sat_oe", oe2, 0);
    chk("sat_bv", bv2, 0);
    req2 = '0;

    // owner drops request: turnaround then next requester
    req = 4'b0010;
    step();
    chk("own1_oe", oe, 4'b0010);
    chk("own1_gid", gid, 1);
    req = 4'b1000;
    step();
    chk("drop_oe", oe, 0);
    chk("drop_z", bz, 1);
    step();
    chk("drop_idle_oe", oe, 0);
    chk("drop_idle_z", bz, 1);
    step();
    chk("next_oe", oe, 4'b1000);
    chk("next_gid", gid, 3);
    chk("next_bus", bus_out, 8'h4D);

    // reset mid-ownership releases immediately
    rst = 1'b1;
    #1;
    chk("mid_oe", oe, 0);
    chk("mid_z", bz, 1);
    chk("mid_bv", bv, 0);
    chk("mid_gid", gid, 0);
    step();
    rst = 1'b0;
    req = 4'b1001;
    step();
    chk("post_gid", gid, 0);
    chk("post_oe", oe, 4'b0001);
    chk("post_bus", bus_out, 8'hA5);
    req = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
